// File: rtl/microwave_timer.sv
// microwave_timer
//   Three-digit BCD countdown timer (M:ST) for the microwave controller.
//   The keypad loads digits by shifting them in from the right. While
//   magnetron is high the time counts down by one second every TICK_DIV
//   clocks. finished_time is high whenever the remaining time is 0:00.
//
//   Optional feature macro: TIMER_ADD30_EN (adds the add30 strobe input).
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   magnetron      run enable; countdown advances only while high
//   clear          synchronous clear of time and prescaler
//   add30          (TIMER_ADD30_EN only) add 30 seconds, saturating at 9:99
//   key_valid      one-cycle strobe qualifying key_digit
//   key_digit      BCD digit 0-9; values above 9 are ignored
//   finished_time  registered, high when the time is 0:00
//   min_ones       minutes digit
//   sec_tens       tens-of-seconds digit (may hold 6-9 after keypad entry)
//   sec_ones       seconds digit
//   tick           one-cycle pulse on each one-second decrement
//
// Handshake: key_valid and add30 are single-cycle strobes with no ready;
// a strobe is either consumed on the edge it is sampled or dropped.
module microwave_timer #(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       magnetron,
    input  logic       clear,
`ifdef TIMER_ADD30_EN
    input  logic       add30,
`endif
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       finished_time,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;
    logic [PW-1:0] pre_n;
    logic [3:0]    m_n;
    logic [3:0]    t_n;
    logic [3:0]    o_n;
    logic          tick_n;
    logic          time_zero;
    logic          run;
    logic          wrap;
`ifdef TIMER_ADD30_EN
    logic [3:0]    t_sum;
`endif

    assign time_zero = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    // The prescaler only advances while there is time left to count.
    assign run  = magnetron && !time_zero;
    assign wrap = run && (pre == PRE_MAX);

    always_comb begin
        m_n    = min_ones;
        t_n    = sec_tens;
        o_n    = sec_ones;
        pre_n  = pre;
        tick_n = 1'b0;
`ifdef TIMER_ADD30_EN
        t_sum  = 4'd0;
`endif
        if (clear) begin
            m_n   = 4'd0;
            t_n   = 4'd0;
            o_n   = 4'd0;
            pre_n = '0;
        end else begin
            if (run) begin
                pre_n = wrap ? '0 : pre + PW'(1);
            end
            if (wrap) begin
                tick_n = 1'b1;
                if (sec_ones != 4'd0) begin
                    o_n = sec_ones - 4'd1;
                end else if (sec_tens != 4'd0) begin
                    t_n = sec_tens - 4'd1;
                    o_n = 4'd9;
                end else begin
                    m_n = min_ones - 4'd1;
                    t_n = 4'd5;
                    o_n = 4'd9;
                end
            end
`ifdef TIMER_ADD30_EN
            // Applied on top of any decrement made in this same cycle.
            if (add30) begin
                t_sum = t_n + 4'd3;
                if (t_sum >= 4'd6) begin
                    if (m_n == 4'd9) begin
                        t_n = 4'd9;
                        o_n = 4'd9;
                    end else begin
                        m_n = m_n + 4'd1;
                        t_n = t_sum - 4'd6;
                    end
                end else begin
                    t_n = t_sum;
                end
            end else
`endif
            if (!magnetron && key_valid && (key_digit <= 4'd9)) begin
                m_n = sec_tens;
                t_n = sec_ones;
                o_n = key_digit;
            end
            // Reaching 0:00 discards any partial second.
            if ((m_n == 4'd0) && (t_n == 4'd0) && (o_n == 4'd0)) begin
                pre_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_ones      <= 4'd0;
            sec_tens      <= 4'd0;
            sec_ones      <= 4'd0;
            pre           <= '0;
            finished_time <= 1'b1;
            tick          <= 1'b0;
        end else begin
            min_ones      <= m_n;
            sec_tens      <= t_n;
            sec_ones      <= o_n;
            pre           <= pre_n;
            finished_time <= (m_n == 4'd0) && (t_n == 4'd0) && (o_n == 4'd0);
            tick          <= tick_n;
        end
    end

endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer with TICK_DIV=4: reset check, a vector table
// for keypad entry and priority, hand-written countdown/pause/reset
// sequences, then randomized traffic against a seconds-level model.
module tb_microwave_timer;

    localparam int TD = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       magnetron = 1'b0;
    logic       clear = 1'b0;
    logic       add30 = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       finished_time;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       tick;

    always #5 clk = ~clk;

    microwave_timer #(.TICK_DIV(TD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .magnetron     (magnetron),
        .clear         (clear),
`ifdef TIMER_ADD30_EN
        .add30         (add30),
`endif
        .key_valid     (key_valid),
        .key_digit     (key_digit),
        .finished_time (finished_time),
        .min_ones      (min_ones),
        .sec_tens      (sec_tens),
        .sec_ones      (sec_ones),
        .tick          (tick)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [13:0] exp_q[$];

    function automatic logic [13:0] pack(int m, int t, int o, bit f, bit k);
        return {4'(m), 4'(t), 4'(o), f, k};
    endfunction

    task automatic check(input string name, input logic [13:0] want);
        logic [13:0] got;
        got = {min_ones, sec_tens, sec_ones, finished_time, tick};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got m:t:o=%h:%h:%h fin=%b tick=%b, want m:t:o=%h:%h:%h fin=%b tick=%b",
                     name, got[13:10], got[9:6], got[5:2], got[1], got[0],
                     want[13:10], want[9:6], want[5:2], want[1], want[0]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit c, input bit kv, input int kd, input bit mag, input bit a);
        clear     = c;
        key_valid = kv;
        key_digit = 4'(kd);
        magnetron = mag;
        add30     = a;
        @(posedge clk);
        #1;
    endtask

    task automatic key(input int d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    // ---------------- reference model (seconds level) ----------------
    // Time is held as whole minutes plus a 0..99 "seconds field"; a
    // decrement is just field-1 (or borrow a minute into 59).
    int  mm, sv, mpre;
    bit  mfin, mtick;

    function automatic void model_step(input bit c, input bit kv, input int kd, input bit mag, input bit a);
        bit dec;
        int t, o;
        dec   = 1'b0;
        mtick = 1'b0;
        if (c) begin
            mm = 0; sv = 0; mpre = 0;
        end else begin
            if (mag && (mm != 0 || sv != 0)) begin
                mpre = mpre + 1;
                if (mpre == TD) begin
                    mpre = 0;
                    dec  = 1'b1;
                end
            end
            if (dec) begin
                mtick = 1'b1;
                if (sv > 0) sv = sv - 1;
                else begin mm = mm - 1; sv = 59; end
            end
            if (a) begin
                t = sv / 10 + 3;
                o = sv % 10;
                if (t >= 6) begin t = t - 6; mm = mm + 1; end
                if (mm > 9) begin mm = 9; t = 9; o = 9; end
                sv = t * 10 + o;
            end else if (!mag && kv && kd <= 9) begin
                mm = sv / 10;
                sv = (sv % 10) * 10 + kd;
            end
        end
        if (mm == 0 && sv == 0) mpre = 0;
        mfin = (mm == 0 && sv == 0);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit       c;
        bit       kv;
        int       kd;
        bit       mag;
        logic [13:0] want;
        string    name;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit c, bit kv, int kd, bit mag, int m, int t, int o, bit f, bit k, string n);
        vec_t v;
        v.c = c; v.kv = kv; v.kd = kd; v.mag = mag;
        v.want = pack(m, t, o, f, k);
        v.name = n;
        return v;
    endfunction

    initial begin
        bit mag_r;
        bit a_r;
        // ---- reset ----
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_state", pack(0, 0, 0, 1, 0));

        // ---- table: keypad, priority ----
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, "key_1"));
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 3, 0, 0, "key_3"));
        tbl.push_back(mk(0, 1, 0, 0, 1, 3, 0, 0, 0, "key_0_130"));
        tbl.push_back(mk(0, 1, 7, 0, 3, 0, 7, 0, 0, "key_7_307"));
        tbl.push_back(mk(0, 1, 12, 0, 3, 0, 7, 0, 0, "key_12_ignored"));
        tbl.push_back(mk(0, 1, 5, 1, 3, 0, 7, 0, 0, "key_while_running"));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, "clear"));
        tbl.push_back(mk(0, 1, 2, 0, 0, 0, 2, 0, 0, "key_2"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 2, 0, 0, 0, "key_0"));
        tbl.push_back(mk(0, 1, 0, 0, 2, 0, 0, 0, 0, "key_0_200"));
        tbl.push_back(mk(1, 1, 4, 0, 0, 0, 0, 1, 0, "clear_beats_key"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, "run_at_zero"));
        foreach (tbl[i]) begin
            step(tbl[i].c, tbl[i].kv, tbl[i].kd, tbl[i].mag, 1'b0);
            check(tbl[i].name, tbl[i].want);
        end

        // ---- countdown 0:02 ----
        key(2);
        check("load_002", pack(0, 0, 2, 0, 0));
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 1, 0);
            if (i < 4)       check("cd_pre1", pack(0, 0, 2, 0, 0));
            else if (i == 4) check("cd_tick1", pack(0, 0, 1, 0, 1));
            else if (i < 8)  check("cd_pre2", pack(0, 0, 1, 0, 0));
            else             check("cd_finish", pack(0, 0, 0, 1, 1));
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0);
            check("cd_hold_zero", pack(0, 0, 0, 1, 0));
        end
        key(1);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 1, 0);
            if (i < 4) check("pre_zero_after_finish", pack(0, 0, 1, 0, 0));
            else       check("pre_zero_tick", pack(0, 0, 0, 1, 1));
        end

        // ---- borrow 1:00 -> 0:59 ----
        key(1); key(0); key(0);
        check("load_100", pack(1, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 0);
        check("borrow_059", pack(0, 5, 9, 0, 1));

        // ---- 0:90 -> 0:89, then pause ----
        step(1, 0, 0, 0, 0);
        key(9); key(0);
        check("load_090", pack(0, 9, 0, 0, 0));
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 0);
        check("dec_089", pack(0, 8, 9, 0, 1));
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("partial_run", pack(0, 8, 9, 0, 0));
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0);
            check("paused", pack(0, 8, 9, 0, 0));
        end
        step(0, 0, 0, 1, 0);
        check("resume_1", pack(0, 8, 9, 0, 0));
        step(0, 0, 0, 1, 0);
        check("resume_tick", pack(0, 8, 8, 0, 1));

        // ---- clear on the wrap cycle ----
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        check("clear_on_wrap", pack(0, 0, 0, 1, 0));

        // ---- reset mid-count ----
        key(3);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        check("async_reset", pack(0, 0, 0, 1, 0));
        #2 rst_n = 1'b1;
        key(1);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 1, 0);
            if (i < 4) check("post_reset_run", pack(0, 0, 1, 0, 0));
            else       check("post_reset_tick", pack(0, 0, 0, 1, 1));
        end

`ifdef TIMER_ADD30_EN
        // ---- add30 ----
        step(1, 0, 0, 0, 0);
        key(4); key(5);
        step(0, 0, 0, 0, 1);
        check("add30_045", pack(1, 1, 5, 0, 0));
        step(1, 0, 0, 0, 0);
        key(9); key(0);
        step(0, 0, 0, 0, 1);
        check("add30_090", pack(1, 6, 0, 0, 0));
        step(1, 0, 0, 0, 0);
        key(9); key(5); key(0);
        step(0, 0, 0, 0, 1);
        check("add30_sat", pack(9, 9, 9, 0, 0));
`endif

        // ---- randomized run against the model ----
        step(1, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0);
        check("rand_start", pack(mm, sv / 10, sv % 10, mfin, mtick));
        mag_r = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            bit c, kv;
            int kd;
            if ($urandom_range(0, 9) == 0) mag_r = ~mag_r;
            c  = ($urandom_range(0, 99) < 2);
            kv = ($urandom_range(0, 2) == 0);
            kd = $urandom_range(0, 15);
`ifdef TIMER_ADD30_EN
            a_r = ($urandom_range(0, 39) == 0);
`else
            a_r = 1'b0;
`endif
            step(c, kv, kd, mag_r, a_r);
            model_step(c, kv, kd, mag_r, a_r);
            exp_q.push_back(pack(mm, sv / 10, sv % 10, mfin, mtick));
            check("random", exp_q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
